fifo_write_arbiter: RTL and testbench

//  Shares the single write port of the synchronous FIFO between N_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 29 ++
 rtl/fifo_write_arbiter_rr_picker.sv | 24 ++
 rtl/fifo_write_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// next_rr is the round-robin scan used by rr_picker.
package fifo_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int RR_MAX_N      = 32;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // First set bit of valid[0..n-1], scanning upward from (last+1) mod n with wrap.
    function automatic int next_rr(input logic [RR_MAX_N-1:0] valid, input int last, input int n);
        int idx;
        logic found;
        next_rr = 0;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX_N; k++) begin
            if (k <= n && !found) begin
                idx = (last + k) % n;
                if (valid[idx[4:0]]) begin
                    next_rr = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin priority scan: valid vector plus last owner
// gives the next owner index and whether anyone is requesting.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [RR_MAX_N-1:0] valid_ext;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = valid;
        pick                   = IDX_W'(next_rr(valid_ext, int'(last), N_REQ));
        any                    = |valid;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the FIFO write port between N_REQ producers with round-robin,
// burst-bounded grants; beats pass straight through to the FIFO.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requesters, no beat accepted
//   GRANT | grant_id owns the write port until last/burst limit/stall
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IDX_W     = $clog2(N_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_wr_data,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] last_grant, last_nxt, grant_nxt, pick_idx;
    logic [CNT_W-1:0] beat_cnt, cnt_nxt;
    logic             pick_any;
    logic             sel_valid, sel_last, beat, release_now;
    logic [DATA_W-1:0] sel_data;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .valid (req_valid),
        .last  (last_grant),
        .pick  (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(N_REQ - 1);
            grant_id   <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            grant_id   <= grant_nxt;
            beat_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        busy      = (state == GRANT);
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_data     = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = busy && !fifo_full;
            end
        end

        // fifo_full gates every transfer, so the FIFO can never be overwritten.
        beat         = busy && sel_valid && !fifo_full;
        fifo_wr_en   = beat;
        fifo_wr_data = beat ? sel_data : '0;
        release_now  = (beat && (sel_last || beat_cnt == CNT_W'(MAX_BURST - 1)))
                     || (busy && !sel_valid && !fifo_full);

        state_nxt = state;
        grant_nxt = grant_id;
        cnt_nxt   = beat_cnt;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (beat)
                    cnt_nxt = beat_cnt + 1'b1;
                if (release_now) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_id;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: producers are beat queues, the reference model tracks
// owner / burst count / last owner from the arbitration rules.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_full, fifo_wr_en, busy;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      grant_id;

    logic [2:0]      v3, l3, rdy3;
    logic [23:0]     d3;
    logic            full3, wr3, busy3;
    logic [7:0]      wdata3;
    logic [1:0]      gid3;

    fifo_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .grant_id(grant_id), .busy(busy)
    );

    fifo_write_arbiter #(.N_REQ(3), .DATA_W(8), .MAX_BURST(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
        .req_last(l3), .req_ready(rdy3), .fifo_full(full3),
        .fifo_wr_en(wr3), .fifo_wr_data(wdata3),
        .grant_id(gid3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] pq[N][$];
    int m_owner, m_last, m_beats;
    logic           exp_busy, exp_wr;
    logic [N-1:0]   exp_ready;
    logic [DW-1:0]  exp_data;

    int         glog[$], blog[$], g3log[$];
    logic [7:0] wlog[$];
    logic       prev_busy = 1'b0, prev_busy3 = 1'b0;

    int fair_order[5] = '{0, 1, 2, 3, 0};
    int n3_order[4]   = '{0, 1, 2, 0};
    int stall_order[3] = '{3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++)
            if (pq[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    task automatic push(input int i, input logic last, input logic [7:0] data);
        pq[i].push_back({last, data});
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
        for (int i = 0; i < N; i++) pq[i].delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = (pq[i].size() > 0);
            req_last[i]            = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
            req_data[i*DW +: DW]   = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
        end
    endtask

    task automatic model_eval();
        exp_busy  = (m_owner >= 0);
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_data  = '0;
        if (m_owner >= 0 && !fifo_full) begin
            exp_ready = N'(1) << m_owner;
            if (pq[m_owner].size() > 0) begin
                exp_wr   = 1'b1;
                exp_data = pq[m_owner][0][7:0];
            end
        end
    endtask

    task automatic model_advance();
        logic [8:0] b;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && pq[c].size() > 0) begin
                    m_owner = c;
                    m_beats = 0;
                end
            end
        end else if (exp_wr) begin
            b = pq[m_owner].pop_front();
            m_beats++;
            if (b[8] || m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!fifo_full) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        model_eval();
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        chk("wr_data", 32'(fifo_wr_data), 32'(exp_data));
        if (exp_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
        if (busy3) chk("n3_gid_range", 32'(gid3 <= 2'd2), 32'd1);
        if (busy && !prev_busy) begin
            glog.push_back(int'(grant_id));
            blog.push_back(0);
        end
        if (fifo_wr_en) begin
            wlog.push_back(fifo_wr_data);
            if (blog.size() > 0) blog[blog.size()-1] = blog[blog.size()-1] + 1;
        end
        if (busy3 && !prev_busy3) g3log.push_back(int'(gid3));
        prev_busy  = busy;
        prev_busy3 = busy3;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        fifo_full = 1'b0;
        while ((m_owner >= 0 || !queues_empty()) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(m_owner < 0 && queues_empty()), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
        chk({tag, "_gid"}, 32'(grant_id), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        v3 = '0; d3 = 24'h332211; l3 = '0; full3 = 1'b0;
        model_reset();
        #3;
        check_reset("rst_init");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset in the middle of a burst
        push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h12); push(0, 1'b1, 8'h13);
        cycle(); cycle();
        drive(); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_wr", 32'(fifo_wr_en), 32'd1);
        rst_n = 1'b0; #1;
        check_reset("rst_mid");
        model_reset();
        drive(); #1;
        rst_n = 1'b1;
        prev_busy = 1'b0;

        // fairness: all four valid, no last; N_REQ=3 instance runs alongside
        glog.delete(); blog.delete(); g3log.delete();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) push(i, 1'b0, 8'((i << 4) | k));
        v3 = 3'b111;
        drain(200);
        v3 = 3'b000;
        cycle(); cycle();
        for (int k = 0; k < 5; k++)
            chk("fair_order", 32'((k < glog.size()) ? glog[k] : -1), 32'(fair_order[k]));
        for (int k = 0; k < 4; k++)
            chk("fair_beats", 32'((k < blog.size()) ? blog[k] : -1), 32'(MB));
        for (int k = 0; k < 4; k++)
            chk("n3_order", 32'((k < g3log.size()) ? g3log[k] : -1), 32'(n3_order[k]));

        // single requester, three-beat packet
        wlog.delete();
        push(1, 1'b0, 8'hA1); push(1, 1'b0, 8'hA2); push(1, 1'b1, 8'hA3);
        drain(20);
        cycle();
        chk("single_count", 32'(wlog.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("single_data", 32'((k < wlog.size()) ? wlog[k] : 8'hxx), 32'(8'hA1 + k));

        // full backpressure on req2's second beat
        wlog.delete();
        push(2, 1'b0, 8'hB1); push(2, 1'b0, 8'hB2); push(2, 1'b1, 8'hB3);
        n = 0;
        while (!(m_owner == 2 && m_beats == 1) && n < 10) begin
            cycle();
            n++;
        end
        chk("bp_reach", 32'(m_owner == 2 && m_beats == 1), 32'd1);
        fifo_full = 1'b1;
        repeat (5) cycle();
        chk("bp_held_count", 32'(wlog.size()), 32'd1);
        drain(20);
        for (int k = 0; k < 3; k++)
            chk("bp_data", 32'((k < wlog.size()) ? wlog[k] : 8'hxx), 32'(8'hB1 + k));

        // stall release with wrap from 3 to 0
        glog.delete();
        push(3, 1'b0, 8'hC1); push(0, 1'b0, 8'hC2); push(1, 1'b0, 8'hC3);
        drain(30);
        for (int k = 0; k < 3; k++)
            chk("stall_order", 32'((k < glog.size()) ? glog[k] : -1), 32'(stall_order[k]));

        // randomized producers and backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0 && pq[i].size() < 4)
                    push(i, ($urandom_range(2) == 0), 8'($urandom));
            fifo_full = ($urandom_range(3) == 0);
            cycle();
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
